// File: rtl/register_file_mp_if.sv
// register_file_mp_if
//   Bundles the register-file access signals between issue/writeback (master)
//   and the register file (slave).
//   wen/wsel/wdat    : write ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
//   rsel/rdat        : read ports (rdat is combinational)
//   busy_set/busy_sel: issue strobe marking a destination register pending
//   busy             : registered scoreboard vector
//   rd_busy          : per-read-port pending indication
//   wr_conflict      : one-cycle flag after a write collision
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [NWR-1:0]        wen;
  logic [NWR*ADDR_W-1:0] wsel;
  logic [NWR*DATA_W-1:0] wdat;
  logic [NRD*ADDR_W-1:0] rsel;
  logic [NRD*DATA_W-1:0] rdat;
  logic                  busy_set;
  logic [ADDR_W-1:0]     busy_sel;
  logic [NREGS-1:0]      busy;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_conflict;

  modport master (
    output wen, wsel, wdat, rsel, busy_set, busy_sel,
    input  rdat, busy, rd_busy, wr_conflict
  );

  modport slave (
    input  wen, wsel, wdat, rsel, busy_set, busy_sel,
    output rdat, busy, rd_busy, wr_conflict
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp
//   Parametrised multi-port register file with register 0 hardwired to zero,
//   optional same-cycle write-to-read bypass, per-register busy scoreboard and
//   a registered write-collision flag.
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : register_file_mp_if slave modport (write/read/scoreboard signals)
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic               CLK,
  input  logic               nRST,
  register_file_mp_if.slave  bus
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs   [NREGS];
  logic [DATA_W-1:0] wr_val [NREGS];
  logic [NREGS-1:0]  wr_hit;
  logic              wr_coll;
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_nxt;
  logic              conflict_q;

  // Resolve write ports per register; later ports overwrite earlier ones so the
  // highest-index port wins. Register 0 is never a target.
  always_comb begin
    wr_hit  = '0;
    wr_coll = 1'b0;
    for (int r = 0; r < NREGS; r++) wr_val[r] = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.wen[k] && (bus.wsel[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          if (wr_hit[r]) wr_coll = 1'b1;
          wr_hit[r] = 1'b1;
          wr_val[r] = bus.wdat[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Clear on writeback first, then apply the issue set so set wins.
  always_comb begin
    busy_nxt = busy_q & ~wr_hit;
    if (bus.busy_set && (bus.busy_sel != '0)) busy_nxt[bus.busy_sel] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
      end
      busy_q     <= busy_nxt;
      conflict_q <= wr_coll;
    end
  end

  // Reads are gated to zero during reset so a bypassed write cannot leak out.
  always_comb begin
    bus.rdat    = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      logic              fwd;
      a   = bus.rsel[i*ADDR_W +: ADDR_W];
      fwd = (BYPASS != 0) && wr_hit[a];
      v   = fwd ? wr_val[a] : regs[a];
      bus.rdat[i*DATA_W +: DATA_W] = nRST ? v : '0;
      bus.rd_busy[i] = busy_q[a] && !fwd;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  register_file_mp_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) bus_b ();
  register_file_mp_if #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) bus_n ();

  register_file_mp #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .CLK(CLK), .nRST(nRST), .bus(bus_b));
  register_file_mp #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
    .CLK(CLK), .nRST(nRST), .bus(bus_n));

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  ws0, ws1;
    logic [31:0] wd0, wd1;
    logic [4:0]  rs0, rs1;
    logic        bset;
    logic [4:0]  bsel;
    logic [31:0] eb0, eb1;   // expected rdat, bypass instance
    logic [31:0] en0, en1;   // expected rdat, no-bypass instance
    logic [1:0]  erdb_b, erdb_n;
    logic [31:0] ebusy;
    logic        econf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  vec_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wen, input logic [4:0] ws0, input logic [4:0] ws1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic bset, input logic [4:0] bsel);
    bus_b.wen = wen; bus_b.wsel = {ws1, ws0}; bus_b.wdat = {wd1, wd0};
    bus_b.rsel = {rs1, rs0}; bus_b.busy_set = bset; bus_b.busy_sel = bsel;
    bus_n.wen = wen; bus_n.wsel = {ws1, ws0}; bus_n.wdat = {wd1, wd0};
    bus_n.rsel = {rs1, rs0}; bus_n.busy_set = bset; bus_n.busy_sel = bsel;
  endtask

  task automatic check_vec(input int idx, input vec_t e);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, "_rd0_byp"},  bus_b.rdat[31:0],  e.eb0);
    chk({p, "_rd1_byp"},  bus_b.rdat[63:32], e.eb1);
    chk({p, "_rd0_nob"},  bus_n.rdat[31:0],  e.en0);
    chk({p, "_rd1_nob"},  bus_n.rdat[63:32], e.en1);
    chk({p, "_rdbusy_byp"}, 32'(bus_b.rd_busy), 32'(e.erdb_b));
    chk({p, "_rdbusy_nob"}, 32'(bus_n.rd_busy), 32'(e.erdb_n));
    chk({p, "_busy_byp"}, bus_b.busy, e.ebusy);
    chk({p, "_busy_nob"}, bus_n.busy, e.ebusy);
    chk({p, "_conf_byp"}, 32'(bus_b.wr_conflict), 32'(e.econf));
    chk({p, "_conf_nob"}, 32'(bus_n.wr_conflict), 32'(e.econf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wen   ws0 ws1 wd0           wd1           rs0 rs1 bs bsel eb0           eb1           en0           en1           rdb_b rdb_n busy   conf
    vecs[0]  = '{2'b01, 0, 0, 32'hDEADBEEF, 32'h0,        0,  0,  0, 0,   32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h0, 1'b0};
    vecs[1]  = '{2'b11, 5, 6, 32'h11111111, 32'h22222222, 5,  6,  0, 0,   32'h11111111, 32'h22222222, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0, 1'b0};
    vecs[2]  = '{2'b00, 0, 0, 32'h0,        32'h0,        5,  6,  0, 0,   32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 2'b00, 2'b00, 32'h0, 1'b0};
    vecs[3]  = '{2'b11, 7, 7, 32'hAAAA0000, 32'h0000BBBB, 7,  0,  0, 0,   32'h0000BBBB, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h0, 1'b0};
    vecs[4]  = '{2'b00, 0, 0, 32'h0,        32'h0,        7,  0,  0, 0,   32'h0000BBBB, 32'h0,        32'h0000BBBB, 32'h0,        2'b00, 2'b00, 32'h0, 1'b1};
    vecs[5]  = '{2'b00, 0, 0, 32'h0,        32'h0,        7,  0,  0, 0,   32'h0000BBBB, 32'h0,        32'h0000BBBB, 32'h0,        2'b00, 2'b00, 32'h0, 1'b0};
    vecs[6]  = '{2'b01, 9, 0, 32'h12345678, 32'h0,        9,  9,  0, 0,   32'h12345678, 32'h12345678, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0, 1'b0};
    vecs[7]  = '{2'b00, 0, 0, 32'h0,        32'h0,        9,  9,  0, 0,   32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 2'b00, 2'b00, 32'h0, 1'b0};
    vecs[8]  = '{2'b00, 0, 0, 32'h0,        32'h0,        3,  0,  1, 3,   32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h0, 1'b0};
    vecs[9]  = '{2'b00, 0, 0, 32'h0,        32'h0,        3,  3,  0, 0,   32'h0,        32'h0,        32'h0,        32'h0,        2'b11, 2'b11, 32'h8, 1'b0};
    vecs[10] = '{2'b01, 3, 0, 32'h33,       32'h0,        3,  0,  0, 0,   32'h33,       32'h0,        32'h0,        32'h0,        2'b00, 2'b01, 32'h8, 1'b0};
    vecs[11] = '{2'b01, 3, 0, 32'h44,       32'h0,        3,  0,  1, 3,   32'h44,       32'h0,        32'h33,       32'h0,        2'b00, 2'b00, 32'h0, 1'b0};
    vecs[12] = '{2'b00, 0, 0, 32'h0,        32'h0,        3,  0,  0, 0,   32'h44,       32'h0,        32'h44,       32'h0,        2'b01, 2'b01, 32'h8, 1'b0};
    vecs[13] = '{2'b00, 0, 0, 32'h0,        32'h0,        0,  0,  1, 0,   32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h8, 1'b0};
    vecs[14] = '{2'b11, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D, 0,  0,  0, 0,   32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 32'h8, 1'b0};
    vecs[15] = '{2'b11, 3, 3, 32'h1,        32'h2,        3,  3,  0, 0,   32'h2,        32'h2,        32'h44,       32'h44,       2'b00, 2'b11, 32'h8, 1'b0};
    vecs[16] = '{2'b00, 0, 0, 32'h0,        32'h0,        3,  3,  0, 0,   32'h2,        32'h2,        32'h2,        32'h2,        2'b00, 2'b00, 32'h0, 1'b1};
    vecs[17] = '{2'b00, 0, 0, 32'h0,        32'h0,        5,  6,  0, 0,   32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 2'b00, 2'b00, 32'h0, 1'b0};

    // Reset state
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", bus_b.busy, 32'h0);
    chk("reset_conf", 32'(bus_b.wr_conflict), 32'h0);
    chk("reset_rd0", bus_b.rdat[31:0], 32'h0);
    nRST = 1'b1;

    // Table: drive at negedge, expectation into scoreboard, compare 1 time unit later
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(vecs[i].wen, vecs[i].ws0, vecs[i].ws1, vecs[i].wd0, vecs[i].wd1,
            vecs[i].rs0, vecs[i].rs1, vecs[i].bset, vecs[i].bsel);
      sb.push_back(vecs[i]);
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty actual=0 expected=1");
      end else begin
        check_vec(i, sb.pop_front());
      end
    end

    // Async reset mid-operation: r4 = 0x55 with busy[4] set in the same cycle
    @(negedge CLK);
    drive(2'b01, 4, 0, 32'h55, 0, 0, 0, 1, 4);
    @(negedge CLK);
    drive(2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
    #1;
    chk("pre_rst_rd0", bus_b.rdat[31:0], 32'h55);
    chk("pre_rst_busy", bus_b.busy, 32'h10);
    chk("pre_rst_rdbusy", 32'(bus_b.rd_busy), 32'h1);
    #1;
    nRST = 1'b0;
    #1;
    chk("async_rst_rd0_byp", bus_b.rdat[31:0], 32'h0);
    chk("async_rst_rd0_nob", bus_n.rdat[31:0], 32'h0);
    chk("async_rst_busy", bus_b.busy, 32'h0);
    chk("async_rst_rdbusy", 32'(bus_b.rd_busy), 32'h0);
    // A write during reset must neither bypass out nor be stored
    drive(2'b01, 4, 0, 32'h99, 0, 4, 0, 1, 4);
    #1;
    chk("rst_held_bypass_rd0", bus_b.rdat[31:0], 32'h0);
    @(negedge CLK);
    drive(2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
    nRST = 1'b1;
    #1;
    chk("post_rst_rd0", bus_b.rdat[31:0], 32'h0);
    chk("post_rst_busy", bus_b.busy, 32'h0);
    chk("post_rst_conf", 32'(bus_b.wr_conflict), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
